// File: rtl/sumador_pkg.sv
// sumador_pkg: shared defaults, stage-1 state encoding and low-half sum helper
package sumador_pkg;
    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_t;
    // Sum of the low l bits of a and b; bit l of the result is the carry.
    function automatic logic [32:0] low_sum(input logic [31:0] a, input logic [31:0] b, input int l);
        logic [31:0] m;
        m = (l >= 32) ? '1 : (32'd1 << l) - 32'd1;
        return {1'b0, a & m} + {1'b0, b & m};
    endfunction
endpackage

// File: rtl/etapa1_entrada_if.sv
// etapa1_entrada_if: operand handshake in, partial-result bundle out
interface etapa1_entrada_if import sumador_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [DATA_W-1:0] dataA, dataB, dataA_d, dataB_d;
    logic [DATA_W/2-1:0] sum10_d;
    logic valid_in, ready_out, ready_d, valid_d, acarreo_d;
    logic [CNT_W-1:0] ops_count;
    modport master(output dataA, dataB, valid_in, ready_d,
                   input ready_out, valid_d, dataA_d, dataB_d, sum10_d, acarreo_d, ops_count);
    modport slave(input dataA, dataB, valid_in, ready_d,
                  output ready_out, valid_d, dataA_d, dataB_d, sum10_d, acarreo_d, ops_count);
endinterface

// File: rtl/skid_reg2.sv
// skid_reg2: two-entry valid/ready skid buffer; in_ready is decoded from state only
module skid_reg2 import sumador_pkg::*; #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    state_t state_q, state_d;
    logic [W-1:0] skid_q;
    logic acc, drn, ld_out, ld_skid, mv;
    assign in_ready = state_q != ST_FULL;
    assign out_valid = state_q != ST_EMPTY;
    assign acc = in_valid && in_ready;
    assign drn = out_valid && out_ready;
    always_comb begin
        state_d = state_q == ST_EMPTY ? (acc ? ST_ONE : ST_EMPTY)
                : state_q == ST_ONE ? (acc && !drn ? ST_FULL : !acc && drn ? ST_EMPTY : ST_ONE)
                : (drn ? ST_ONE : ST_FULL);
        ld_out = acc && (state_q == ST_EMPTY || drn);
        ld_skid = acc && state_q == ST_ONE && !drn;
        mv = state_q == ST_FULL && drn;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            out_data <= '0;
            skid_q <= '0;
        end else begin
            state_q <= state_d;
            if (ld_out) out_data <= in_data;
            else if (mv) out_data <= skid_q;
            if (ld_skid) skid_q <= in_data;
        end
    end
endmodule

// File: rtl/etapa1_entrada.sv
// etapa1_entrada: first adder stage; low-half sum/carry computed on entry and
// carried with the operands through a 2-entry skid buffer, plus an accept counter
module etapa1_entrada import sumador_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic clk,
    input logic reset,
    etapa1_entrada_if.slave bus
);
    localparam int L = DATA_W / 2;
    localparam int W = 2 * DATA_W + L + 1;
    logic [L:0] low;
    logic [W-1:0] in_bundle, out_bundle;
    assign low = (L+1)'(low_sum(32'(bus.dataA), 32'(bus.dataB), L));
    assign in_bundle = {bus.dataA, bus.dataB, low};
    skid_reg2 #(.W(W)) u_skid (
        .clk(clk),
        .reset(reset),
        .in_data(in_bundle),
        .in_valid(bus.valid_in),
        .in_ready(bus.ready_out),
        .out_data(out_bundle),
        .out_valid(bus.valid_d),
        .out_ready(bus.ready_d)
    );
    assign {bus.dataA_d, bus.dataB_d, bus.acarreo_d, bus.sum10_d} = out_bundle;
    always_ff @(posedge clk) begin
        if (reset) bus.ops_count <= '0;
        else if (bus.valid_in && bus.ready_out) bus.ops_count <= bus.ops_count + 1'b1;
    end
endmodule

// File: tb/tb_etapa1_entrada.sv
// tb_etapa1_entrada: FIFO-queue reference model checked every cycle, plus directed literal checks
module tb_etapa1_entrada;
    typedef struct {logic [3:0] a; logic [3:0] b;} pair_t;
    logic clk = 0;
    logic reset = 0;
    int checks = 0;
    int errors = 0;
    bit live = 0;
    pair_t q[$];
    pair_t shown;
    int cnt;
    etapa1_entrada_if #(.DATA_W(4), .CNT_W(8)) bus ();
    etapa1_entrada #(.DATA_W(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference: a queue of at most two pending pairs; outputs show the head,
    // or the most recently drained pair when nothing is pending.
    always @(posedge clk) begin
        bit acc, drn;
        if (reset) begin
            q.delete();
            shown = '{4'd0, 4'd0};
            cnt = 0;
            live = 1;
        end else if (live) begin
            acc = bus.valid_in && q.size() < 2;
            drn = q.size() > 0 && bus.ready_d;
            if (drn) shown = q.pop_front();
            if (acc) begin
                q.push_back('{bus.dataA, bus.dataB});
                cnt = (cnt + 1) % 256;
            end
        end
    end

    always @(negedge clk) begin
        pair_t e;
        int s;
        if (live) begin
            e = q.size() > 0 ? q[0] : shown;
            s = int'(e.a % 4) + int'(e.b % 4);
            chk("valid_d", 32'(bus.valid_d), 32'(q.size() > 0));
            chk("ready_out", 32'(bus.ready_out), 32'(q.size() < 2));
            chk("dataA_d", 32'(bus.dataA_d), 32'(e.a));
            chk("dataB_d", 32'(bus.dataB_d), 32'(e.b));
            chk("sum10_d", 32'(bus.sum10_d), 32'(s % 4));
            chk("acarreo_d", 32'(bus.acarreo_d), 32'(s / 4));
            chk("ops_count", 32'(bus.ops_count), 32'(cnt));
        end
    end

    task automatic drive(input bit r, input bit v, input int a, input int b, input bit rd);
        @(negedge clk);
        #1;
        reset = r;
        bus.valid_in = v;
        bus.dataA = 4'(a);
        bus.dataB = 4'(b);
        bus.ready_d = rd;
    endtask

    task automatic settle;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string n, input int a, input int b, input int s, input int c, input int ops);
        chk({n, ".valid"}, 32'(bus.valid_d), 1);
        chk({n, ".A"}, 32'(bus.dataA_d), 32'(a));
        chk({n, ".B"}, 32'(bus.dataB_d), 32'(b));
        chk({n, ".sum"}, 32'(bus.sum10_d), 32'(s));
        chk({n, ".carry"}, 32'(bus.acarreo_d), 32'(c));
        chk({n, ".ops"}, 32'(bus.ops_count), 32'(ops));
    endtask

    task automatic check_reset(input string n);
        chk({n, ".valid"}, 32'(bus.valid_d), 0);
        chk({n, ".ready"}, 32'(bus.ready_out), 1);
        chk({n, ".bundle"}, {bus.dataA_d, bus.dataB_d, bus.sum10_d, bus.acarreo_d, bus.ops_count}, 0);
    endtask

    initial begin
        bus.valid_in = 0; bus.dataA = 0; bus.dataB = 0; bus.ready_d = 0;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        settle();
        check_reset("reset");
        drive(0, 1, 6, 7, 1);
        settle();
        lit("first", 6, 7, 1, 1, 1);
        // back-to-back stream
        drive(1, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) drive(0, 1, i, 15 - i, 1);
        settle();
        lit("stream", 15, 0, 3, 0, 16);
        chk("stream.ready", 32'(bus.ready_out), 1);
        // stall into FULL, then release
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 3, 1, 0);
        drive(0, 1, 2, 2, 0);
        drive(0, 1, 9, 9, 0);
        settle();
        lit("stall", 3, 1, 0, 1, 2);
        chk("stall.ready", 32'(bus.ready_out), 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        settle();
        lit("release", 2, 2, 0, 1, 2);
        chk("release.ready", 32'(bus.ready_out), 1);
        drive(0, 0, 0, 0, 1);
        settle();
        chk("drained.valid", 32'(bus.valid_d), 0);
        chk("drained.hold", 32'(bus.dataA_d), 2);
        // carry corners
        drive(0, 1, 0, 0, 1);
        settle();
        lit("zero", 0, 0, 0, 0, 3);
        drive(0, 1, 15, 15, 1);
        settle();
        lit("ff", 15, 15, 2, 1, 4);
        // counter wrap
        drive(1, 0, 0, 0, 1);
        for (int i = 0; i < 256; i++) drive(0, 1, $urandom_range(15), $urandom_range(15), 1);
        drive(0, 0, 0, 0, 1);
        settle();
        chk("wrap.ops", 32'(bus.ops_count), 0);
        // reset while FULL
        drive(0, 1, 4, 4, 0);
        drive(0, 1, 5, 5, 0);
        drive(1, 1, 7, 7, 1);
        settle();
        check_reset("rstfull");
        drive(0, 1, 5, 6, 1);
        settle();
        lit("after_rst", 5, 6, 3, 0, 1);
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(63) == 0, $urandom_range(3) != 0,
                  $urandom_range(15), $urandom_range(15), $urandom_range(2) != 0);
        drive(0, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
